// File: rtl/ic_hc_block_scheduler.sv
// Block scheduler for the Huffman coder: walks the per-MCU component slots,
// launches one block at a time and tracks completed MCUs up to the image limit.
module ic_hc_block_scheduler #(
   parameter int MCU_W = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cfg_start,
   input  logic             cfg_mode,
   input  logic [MCU_W-1:0] cfg_num_mcu,
   input  logic             blk_valid,
   input  logic             blk_done,
   output logic             blk_start,
   output logic [1:0]       blk_comp,
   output logic [2:0]       diff_clear,
   output logic             busy,
   output logic             eoi,
   output logic [MCU_W-1:0] mcu_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_DATA = 3'd1,
      S_ISSUE     = 3'd2,
      S_CODING    = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       slot_q, slot_d;
   logic             mode_q, mode_d;
   logic [MCU_W-1:0] limit_q, limit_d;
   logic [MCU_W-1:0] cnt_q, cnt_d;
   logic             blk_start_q, blk_start_d;
   logic [1:0]       comp_q, comp_d;
   logic [2:0]       dclr_q, dclr_d;
   logic             busy_q, busy_d;
   logic             eoi_q, eoi_d;

   logic             accept;
   logic             last_slot;
   logic             last_mcu;
   logic [MCU_W-1:0] cnt_inc;
   logic [1:0]       comp_sel;

   assign accept    = cfg_start && (cfg_num_mcu != '0);
   assign last_slot = mode_q ? (slot_q == 3'd5) : (slot_q == 3'd2);
   // limit is nonzero and count stops at it, so cnt_q + 1 cannot wrap
   assign cnt_inc   = cnt_q + 1'b1;
   assign last_mcu  = (cnt_inc == limit_q);

   // 4:2:0 sends four luma blocks before Cb and Cr
   always_comb begin
      comp_sel = 2'b00;
      if (!mode_q)               comp_sel = slot_q[1:0];
      else if (slot_q == 3'd4)   comp_sel = 2'b01;
      else if (slot_q == 3'd5)   comp_sel = 2'b10;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         slot_q      <= '0;
         mode_q      <= 1'b0;
         limit_q     <= '0;
         cnt_q       <= '0;
         blk_start_q <= 1'b0;
         comp_q      <= 2'b00;
         dclr_q      <= 3'b000;
         busy_q      <= 1'b0;
         eoi_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         mode_q      <= mode_d;
         limit_q     <= limit_d;
         cnt_q       <= cnt_d;
         blk_start_q <= blk_start_d;
         comp_q      <= comp_d;
         dclr_q      <= dclr_d;
         busy_q      <= busy_d;
         eoi_q       <= eoi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (accept) state_d = S_WAIT_DATA;
         S_WAIT_DATA: if (blk_valid) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_CODING;
         S_CODING: begin
            if (blk_done) begin
               if (last_slot && last_mcu) state_d = S_DONE;
               else                       state_d = S_WAIT_DATA;
            end
         end
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output and datapath next-state; pulses default low, everything else holds
   always_comb begin
      slot_d      = slot_q;
      mode_d      = mode_q;
      limit_d     = limit_q;
      cnt_d       = cnt_q;
      comp_d      = comp_q;
      busy_d      = busy_q;
      blk_start_d = 1'b0;
      dclr_d      = 3'b000;
      eoi_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               mode_d  = cfg_mode;
               limit_d = cfg_num_mcu;
               slot_d  = '0;
               cnt_d   = '0;
               dclr_d  = 3'b111;
               busy_d  = 1'b1;
            end
         end
         S_WAIT_DATA: begin
            if (blk_valid) begin
               blk_start_d = 1'b1;
               comp_d      = comp_sel;
            end
         end
         S_CODING: begin
            if (blk_done) begin
               if (last_slot) begin
                  slot_d = '0;
                  cnt_d  = cnt_inc;
                  if (last_mcu) begin
                     eoi_d  = 1'b1;
                     busy_d = 1'b0;
                  end
               end else begin
                  slot_d = slot_q + 3'd1;
               end
            end
         end
         default: ;
      endcase
   end

   assign blk_start  = blk_start_q;
   assign blk_comp   = comp_q;
   assign diff_clear = dclr_q;
   assign busy       = busy_q;
   assign eoi        = eoi_q;
   assign mcu_count  = cnt_q;

endmodule

// File: tb/tb_ic_hc_block_scheduler.sv
// Scoreboard bench for ic_hc_block_scheduler: the image model pushes the expected
// block sequence and eoi; an independent monitor checks every DUT output cycle.
module tb_ic_hc_block_scheduler;

   localparam int MCU_W = 20;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             cfg_start = 1'b0;
   logic             cfg_mode = 1'b0;
   logic [MCU_W-1:0] cfg_num_mcu = '0;
   logic             blk_valid;
   logic             blk_done;
   logic             blk_start;
   logic [1:0]       blk_comp;
   logic [2:0]       diff_clear;
   logic             busy;
   logic             eoi;
   logic [MCU_W-1:0] mcu_count;

   logic man_valid = 1'b0, rand_valid_en = 1'b0, valid_rand = 1'b0;
   logic man_done = 1'b0, coder_done = 1'b0;
   bit   auto_coder = 1'b0;
   int   fixed_delay = 0;
   int   gen = 0;

   assign blk_valid = rand_valid_en ? valid_rand : man_valid;
   assign blk_done  = man_done | coder_done;

   ic_hc_block_scheduler #(.MCU_W(MCU_W)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
      .cfg_num_mcu(cfg_num_mcu), .blk_valid(blk_valid), .blk_done(blk_done),
      .blk_start(blk_start), .blk_comp(blk_comp), .diff_clear(diff_clear),
      .busy(busy), .eoi(eoi), .mcu_count(mcu_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct {
      logic [1:0] comp;
      int         mcu;
   } blk_t;

   blk_t blk_q[$];
   int   eoi_q[$];
   int   dclr_pend = 0;
   int   start_cnt = 0;
   int   eoi_cnt = 0;
   int   img_expected = 0;

   // Component order inside one MCU for each sampling mode
   function automatic logic [1:0] comp_of(input bit m, input int s);
      logic [1:0] r;
      if (!m)       r = 2'(s);
      else if (s < 4) r = 2'd0;
      else          r = 2'(s - 3);
      return r;
   endfunction

   // Monitor
   bit         in_img = 0, coding = 0, tail = 0, prev_done = 0, exp_eoi_next = 0;
   int         exp_idle_cnt = 0;
   logic [1:0] last_comp = 2'b00;

   always @(negedge clk) begin
      bit cur_done;
      if (!reset_n) begin
         in_img = 0; coding = 0; tail = 0; prev_done = 0; exp_eoi_next = 0;
         exp_idle_cnt = 0; last_comp = 2'b00;
      end else begin
         cur_done = coding && blk_done;
         chk("eoi_timing", 32'(eoi), 32'(exp_eoi_next));
         if (prev_done) chk("start_gap_after_done", 32'(blk_start), 0);
         if (diff_clear != 3'b000) begin
            chk("diff_clear_value", 32'(diff_clear), 7);
            chk("diff_clear_expected", 32'(dclr_pend > 0), 1);
            if (dclr_pend > 0) dclr_pend--;
            in_img = 1;
         end
         if (blk_start) begin
            start_cnt++;
            if (blk_q.size() == 0) chk("unexpected_blk_start", 1, 0);
            else begin
               blk_t e;
               e = blk_q.pop_front();
               chk("blk_comp", 32'(blk_comp), 32'(e.comp));
               chk("mcu_count_at_start", 32'(mcu_count), e.mcu);
            end
            last_comp = blk_comp;
            coding = 1;
         end else if (coding || tail) begin
            chk("blk_comp_stable", 32'(blk_comp), 32'(last_comp));
         end
         if (eoi) begin
            eoi_cnt++;
            if (eoi_q.size() == 0) chk("unexpected_eoi", 1, 0);
            else begin
               int n;
               n = eoi_q.pop_front();
               chk("mcu_count_at_eoi", 32'(mcu_count), n);
               chk("blocks_left_at_eoi", blk_q.size(), 0);
               exp_idle_cnt = n;
            end
            in_img = 0;
         end
         chk("busy", 32'(busy), 32'(in_img));
         if (!busy) chk("mcu_count_idle", 32'(mcu_count), exp_idle_cnt);
         exp_eoi_next = cur_done && (blk_q.size() == 0) && (eoi_q.size() > 0);
         prev_done = cur_done;
         tail = cur_done;
         if (cur_done) coding = 0;
      end
   end

   // Coder model: answers each blk_start with one blk_done pulse
   initial forever begin
      @(negedge clk);
      if (reset_n && auto_coder && blk_start) begin
         int g, d;
         g = gen;
         d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 5));
         repeat (d) @(posedge clk);
         #1;
         if (g == gen) begin
            coder_done = 1'b1;
            @(posedge clk); #1;
            coder_done = 1'b0;
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      valid_rand = ($urandom_range(0, 3) != 0);
   end

   task automatic start_image(input bit m, input int n);
      int bpm;
      bpm = m ? 6 : 3;
      @(posedge clk); #1;
      for (int k = 0; k < n; k++)
         for (int s = 0; s < bpm; s++) begin
            blk_t e;
            e.comp = comp_of(m, s);
            e.mcu  = k;
            blk_q.push_back(e);
         end
      eoi_q.push_back(n);
      dclr_pend++;
      img_expected++;
      cfg_start = 1'b1; cfg_mode = m; cfg_num_mcu = MCU_W'(n);
      @(posedge clk); #1;
      cfg_start = 1'b0; cfg_mode = 1'($urandom); cfg_num_mcu = MCU_W'($urandom_range(0, 9));
   endtask

   task automatic wait_img(input int budget);
      int c = 0;
      while (eoi_cnt < img_expected && c < budget) begin
         @(posedge clk); c++;
      end
      chk("image_completed_in_budget", 32'(eoi_cnt >= img_expected), 1);
   endtask

   task automatic chk_reset_vals();
      chk("rst_blk_start", 32'(blk_start), 0);
      chk("rst_blk_comp", 32'(blk_comp), 0);
      chk("rst_diff_clear", 32'(diff_clear), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_eoi", 32'(eoi), 0);
      chk("rst_mcu_count", 32'(mcu_count), 0);
   endtask

   initial begin
      int s0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #1 reset_n = 1'b1;

      // Mode 0, one MCU, done three cycles after each start
      auto_coder = 1; fixed_delay = 3; man_valid = 1'b1;
      start_image(1'b0, 1);
      wait_img(500);
      @(negedge clk);
      chk("single_mcu_final_count", 32'(mcu_count), 1);

      // Mode 1, two MCUs, bursty data
      fixed_delay = 0; rand_valid_en = 1'b1;
      start_image(1'b1, 2);
      wait_img(2000);

      // Zero-MCU request in IDLE is ignored
      @(posedge clk); #1 cfg_start = 1'b1; cfg_num_mcu = '0; cfg_mode = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("zero_mcu_ignored_busy", 32'(busy), 0);
      chk("zero_mcu_ignored_count", 32'(mcu_count), 2);

      // Stall in WAIT_DATA, with stray cfg_start and blk_done during the stall
      rand_valid_en = 1'b0; man_valid = 1'b0;
      start_image(1'b0, 2);
      s0 = start_cnt;
      repeat (3) @(posedge clk);
      #1 man_done = 1'b1;
      @(posedge clk); #1 man_done = 1'b0;
      cfg_start = 1'b1; cfg_mode = 1'b1; cfg_num_mcu = MCU_W'(7);
      @(posedge clk); #1 cfg_start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("stall_no_start", start_cnt - s0, 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_mcu_count", 32'(mcu_count), 0);
      @(posedge clk); #1 man_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("start_latency", 32'(blk_start), 1);
      rand_valid_en = 1'b1;
      wait_img(2000);

      // Reset while block 2 of a mode 1 image is being coded
      start_image(1'b1, 3);
      s0 = start_cnt;
      begin
         int c = 0;
         while (start_cnt < s0 + 2 && c < 500) begin
            @(posedge clk); c++;
         end
         chk("reach_block2", 32'(start_cnt >= s0 + 2), 1);
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      gen++;
      blk_q.delete(); eoi_q.delete(); dclr_pend = 0; img_expected--;
      @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #1 reset_n = 1'b1;
      start_image(1'b0, 1);
      wait_img(1000);

      // Random images
      for (int i = 0; i < 6; i++) begin
         start_image(1'($urandom), int'($urandom_range(1, 4)));
         wait_img(4000);
      end
      repeat (4) @(posedge clk);
      chk("eoi_total", eoi_cnt, img_expected);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ic_hc_block_scheduler.md
IC_HC_BLOCK_SCHEDULER -- requirements
Module: ic_hc_block_scheduler

Interface
REQ-001 SHALL have parameter MCU_W, default 20, width of the MCU count and limit.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cfg_start  input  1  single-cycle request to begin an image.
REQ-005 SHALL have port cfg_mode  input  1  sampling mode: 0 = 4:4:4 (Y,Cb,Cr); 1 = 4:2:0 (Y,Y,Y,Y,Cb,Cr).
REQ-006 SHALL have port cfg_num_mcu  input  MCU_W  number of MCUs in the image.
REQ-007 SHALL have port blk_valid  input  1  upstream FIFO holds a complete block (not empty).
REQ-008 SHALL have port blk_done  input  1  single-cycle pulse from the coder after EOB is emitted.
REQ-009 SHALL have port blk_start  output  1  single-cycle pulse that launches coding of one block.
REQ-010 SHALL have port blk_comp  output  2  component of the current block: 00 Y, 01 Cb, 10 Cr.
REQ-011 SHALL have port diff_clear  output  3  DC-predictor clear; bit0 Y, bit1 Cb, bit2 Cr.
REQ-012 SHALL have port busy  output  1  high from image acceptance until eoi.
REQ-013 SHALL have port eoi  output  1  single-cycle end-of-image pulse.
REQ-014 SHALL have port mcu_count  output  MCU_W  number of MCUs completed in the current image.

Function
REQ-015 SHALL implement states IDLE, WAIT_DATA, ISSUE, CODING and DONE; all outputs SHALL be registered.
REQ-016 IDLE: when cfg_start=1 and cfg_num_mcu!=0, SHALL latch cfg_mode and cfg_num_mcu, clear slot and mcu_count, drive diff_clear=111 for exactly the next cycle, set busy, and go to WAIT_DATA.
REQ-017 IDLE: when cfg_start=1 and cfg_num_mcu=0, SHALL ignore the request: no state change, busy and diff_clear stay 0.
REQ-018 WAIT_DATA: when blk_valid=1, SHALL go to ISSUE; blk_start SHALL be high for the single cycle spent in ISSUE (latency: blk_valid at cycle M gives blk_start at M+1).
REQ-019 ISSUE: SHALL go unconditionally to CODING.
REQ-020 blk_comp SHALL be derived from slot: mode 0 slots 0,1,2 give 00,01,10; mode 1 slots 0-3 give 00 and slots 4,5 give 01,10.
REQ-021 blk_comp SHALL be stable from the blk_start cycle until the cycle after the matching blk_done.
REQ-022 CODING: on blk_done, if slot is not the last slot (2 in mode 0, 5 in mode 1), SHALL increment slot and go to WAIT_DATA.
REQ-023 CODING: on blk_done at the last slot, SHALL reset slot to 0 and increment mcu_count; if the new count equals the latched limit, SHALL go to DONE, otherwise to WAIT_DATA.
REQ-024 DONE: SHALL pulse eoi for one cycle, clear busy in the same cycle, and go to IDLE; mcu_count SHALL hold its final value until the next accepted cfg_start.
REQ-025 Timing: blk_done at cycle D gives eoi at D+1 for the last block; for other blocks the next blk_start is no earlier than D+2.
REQ-026 blk_done outside CODING SHALL be ignored.
REQ-027 cfg_start while busy=1 SHALL be ignored; cfg_mode and cfg_num_mcu changes mid-image SHALL have no effect.
REQ-028 blk_valid low in WAIT_DATA SHALL stall indefinitely, with no timeout.
REQ-029 mcu_count SHALL never exceed the latched limit, so no wrap-around is possible.

Reset
REQ-030 While reset_n=0 at a clock edge, SHALL enter IDLE with slot=0, mcu_count=0, blk_start=0, blk_comp=00, diff_clear=000, busy=0, eoi=0 and latched config=0.
REQ-031 Reset mid-image SHALL abandon the image with no eoi; the first post-reset cfg_start SHALL behave as a fresh image.

Verification
REQ-032 Mode 0, num_mcu=1, blk_valid=1, blk_done 3 cycles after each blk_start -> blk_comp sequence 00,01,10; diff_clear=111 once; eoi one cycle after 3rd blk_done; mcu_count=1.
REQ-033 Mode 1, num_mcu=2 -> 12 blk_start pulses with blk_comp 00,00,00,00,01,10 repeated; mcu_count steps 1 then 2; eoi once.
REQ-034 blk_valid held low 10 cycles in WAIT_DATA -> no blk_start during the hold; blk_start one cycle after blk_valid rises.
REQ-035 cfg_start with num_mcu=0, then cfg_start during busy, then blk_done pulse in WAIT_DATA -> all ignored; busy, slot and mcu_count unchanged.
REQ-036 reset_n low during CODING of block 2, then a new cfg_start -> outputs at reset values, no eoi, first blk_comp=00, diff_clear=111.
